// File: rtl/cic_integrator_chain.sv
// Time-multiplexed cascade of ORDER integrators for the decimating CIC front end.
// Each stage keeps one accumulator per channel and registers its sum with the tag for the next stage.
module cic_integrator_chain #(
    parameter int WIDTH     = 16,
    parameter int ORDER     = 3,
    parameter int GROWTH    = 7,
    parameter int CHANNELS  = 2,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int OUT_WIDTH = WIDTH + GROWTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [CH_W-1:0]      in_chan,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_chan,
    output logic [OUT_WIDTH-1:0] out_data
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [OUT_WIDTH-1:0] acc_r        [ORDER][CHANNELS];
    logic                 pipe_valid_r [ORDER];
    logic [CH_W-1:0]      pipe_chan_r  [ORDER];
    logic [OUT_WIDTH-1:0] pipe_data_r  [ORDER];

    logic                 stage_valid_s [ORDER];
    logic [CH_W-1:0]      stage_chan_s  [ORDER];
    logic [OUT_WIDTH-1:0] stage_data_s  [ORDER];
    logic [OUT_WIDTH-1:0] sum_s         [ORDER];

    logic in_ok_s;

    // Samples tagged with a channel that does not exist are dropped at the door.
    assign in_ok_s = in_valid && ({1'b0, in_chan} < CH_LIMIT);

    genvar k;
    generate
        for (k = 0; k < ORDER; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign stage_valid_s[k] = in_ok_s;
                assign stage_chan_s[k]  = in_chan;
                assign stage_data_s[k]  = OUT_WIDTH'($signed(in_data));
            end else begin : g_next
                assign stage_valid_s[k] = pipe_valid_r[k-1];
                assign stage_chan_s[k]  = pipe_chan_r[k-1];
                assign stage_data_s[k]  = pipe_data_r[k-1];
            end
            // Modular sum: the comb section downstream relies on wrap-around.
            assign sum_s[k] = acc_r[k][stage_chan_s[k]] + stage_data_s[k];
        end
    endgenerate

    // Accumulator and stage pipeline update; clear beats data, enable gates everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < ORDER; s++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_r[s][c] <= '0;
                end
                pipe_valid_r[s] <= 1'b0;
                pipe_chan_r[s]  <= '0;
                pipe_data_r[s]  <= '0;
            end
        end else if (clk_en) begin
            if (clr) begin
                // Data/tag registers keep their last values so out_data/out_chan hold.
                for (int s = 0; s < ORDER; s++) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_r[s][c] <= '0;
                    end
                    pipe_valid_r[s] <= 1'b0;
                end
            end else begin
                for (int s = 0; s < ORDER; s++) begin
                    pipe_valid_r[s] <= stage_valid_s[s];
                    if (stage_valid_s[s]) begin
                        acc_r[s][stage_chan_s[s]] <= sum_s[s];
                        pipe_chan_r[s]            <= stage_chan_s[s];
                        pipe_data_r[s]            <= sum_s[s];
                    end
                end
            end
        end
    end

    assign out_valid = pipe_valid_r[ORDER-1];
    assign out_chan  = pipe_chan_r[ORDER-1];
    assign out_data  = pipe_data_r[ORDER-1];

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Directed bench for cic_integrator_chain: three configurations (3rd order/2 ch,
// 2nd order/3 ch, 1st order 4-bit wrap) driven from one linear stimulus sequence.
module tb_cic_integrator_chain;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_en, a_clr, a_valid, a_ovalid;
    logic [0:0]  a_chan, a_ochan;
    logic [15:0] a_data;
    logic [22:0] a_odata;

    logic        b_en, b_clr, b_valid, b_ovalid;
    logic [1:0]  b_chan, b_ochan;
    logic [15:0] b_data;
    logic [22:0] b_odata;

    logic        c_en, c_clr, c_valid, c_ovalid;
    logic [0:0]  c_chan, c_ochan;
    logic [3:0]  c_data;
    logic [3:0]  c_odata;

    int checks   = 0;
    int failures = 0;

    int ea [8] = '{1, -1, 4, -4, 10, -10, 20, -20};
    int eb [5] = '{1, 3, 6, 10, 15};
    int ec [4] = '{7, -2, 5, -4};
    int er [3] = '{1, 4, 10};
    int rc [3] = '{1, 1, 0};
    int re [3] = '{-35, -56, 35};

    cic_integrator_chain #(.WIDTH(16), .ORDER(3), .GROWTH(7), .CHANNELS(2)) dut_a (
        .clk(clk), .rst(rst), .clk_en(a_en), .clr(a_clr), .in_valid(a_valid),
        .in_chan(a_chan), .in_data(a_data), .out_valid(a_ovalid),
        .out_chan(a_ochan), .out_data(a_odata));

    cic_integrator_chain #(.WIDTH(16), .ORDER(2), .GROWTH(7), .CHANNELS(3)) dut_b (
        .clk(clk), .rst(rst), .clk_en(b_en), .clr(b_clr), .in_valid(b_valid),
        .in_chan(b_chan), .in_data(b_data), .out_valid(b_ovalid),
        .out_chan(b_ochan), .out_data(b_odata));

    cic_integrator_chain #(.WIDTH(4), .ORDER(1), .GROWTH(0), .CHANNELS(2)) dut_c (
        .clk(clk), .rst(rst), .clk_en(c_en), .clr(c_clr), .in_valid(c_valid),
        .in_chan(c_chan), .in_data(c_data), .out_valid(c_ovalid),
        .out_chan(c_ochan), .out_data(c_odata));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_en = 1'b1; a_clr = 1'b0; a_valid = 1'b0; a_chan = 1'b0; a_data = 16'd0;
        b_en = 1'b1; b_clr = 1'b0; b_valid = 1'b0; b_chan = 2'd0; b_data = 16'd0;
        c_en = 1'b1; c_clr = 1'b0; c_valid = 1'b0; c_chan = 1'b0; c_data = 4'd0;
        tick();
        tick();
        chk("rst_a_valid", a_ovalid, 0);
        chk("rst_a_data", $signed(a_odata), 0);
        chk("rst_a_chan", a_ochan, 0);
        chk("rst_b_valid", b_ovalid, 0);
        chk("rst_c_data", $signed(c_odata), 0);
        rst = 1'b0;

        // 4-bit first-order integrator wraps modulo 16
        c_valid = 1'b1; c_data = 4'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_wrap_valid", c_ovalid, 1);
            chk("c_wrap_data", $signed(c_odata), ec[i]);
        end
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        chk("c_clr_valid", c_ovalid, 0);
        chk("c_clr_hold", $signed(c_odata), -4);
        c_data = 4'h8;
        tick();
        chk("c_neg8_first", $signed(c_odata), -8);
        tick();
        chk("c_neg8_second", $signed(c_odata), 0);
        c_valid = 1'b0;

        // second-order step on channel 2, latency 2
        b_valid = 1'b1; b_chan = 2'd2; b_data = 16'd1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) b_valid = 1'b0;
            tick();
            if (i >= 1) begin
                chk("b_step_valid", b_ovalid, 1);
                chk("b_step_chan", b_ochan, 2);
                chk("b_step_data", $signed(b_odata), eb[i-1]);
            end else begin
                chk("b_step_latency", b_ovalid, 0);
            end
        end
        tick();
        chk("b_idle_valid", b_ovalid, 0);
        chk("b_idle_hold", $signed(b_odata), 15);

        // tag 3 does not exist in a 3-channel instance
        b_valid = 1'b1; b_chan = 2'd3; b_data = 16'd50;
        tick();
        b_valid = 1'b0;
        tick();
        chk("b_oor_valid", b_ovalid, 0);
        chk("b_oor_hold", $signed(b_odata), 15);

        // impulse on channel 0 gives a ramp
        b_valid = 1'b1; b_chan = 2'd0; b_data = 16'd1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) b_data = 16'd0;
            tick();
            if (i >= 1) chk("b_impulse", $signed(b_odata), i);
        end
        b_valid = 1'b0;

        // clear mid-stream on channel 1 while a sample is presented
        b_valid = 1'b1; b_chan = 2'd1; b_data = 16'd1;
        tick();
        tick();
        chk("b_pre_clr_1", $signed(b_odata), 1);
        tick();
        chk("b_pre_clr_3", $signed(b_odata), 3);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("b_clr_valid", b_ovalid, 0);
        chk("b_clr_hold_data", $signed(b_odata), 3);
        chk("b_clr_hold_chan", b_ochan, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) b_valid = 1'b0;
            tick();
            if (i >= 1) chk("b_restart", $signed(b_odata), eb[i-1]);
        end
        b_valid = 1'b1; b_chan = 2'd2;
        tick();
        b_valid = 1'b0;
        tick();
        chk("b_ch2_cleared", $signed(b_odata), 1);
        chk("b_ch2_chan", b_ochan, 2);

        // third order, channels interleaved with opposite steps
        a_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                a_chan = 1'(i % 2);
                a_data = (i % 2 == 1) ? 16'hFFFF : 16'd1;
            end else begin
                a_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                chk("a_il_valid", a_ovalid, 1);
                chk("a_il_chan", a_ochan, (i - 2) % 2);
                chk("a_il_data", $signed(a_odata), ea[i-2]);
            end
        end
        tick();
        chk("a_il_idle", a_ovalid, 0);
        chk("a_il_hold", $signed(a_odata), -20);

        // channel 1 alone, then channel 0 resumes from its own state
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                a_valid = 1'b1;
                a_chan = 1'(rc[i]);
                a_data = (rc[i] == 1) ? 16'hFFFF : 16'd1;
            end else begin
                a_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                chk("a_resume_chan", a_ochan, rc[i-2]);
                chk("a_resume_data", $signed(a_odata), re[i-2]);
            end
        end

        // clock-enable freeze with a sample in flight; in_valid is ignored meanwhile
        a_valid = 1'b1; a_chan = 1'b0; a_data = 16'd1;
        tick();
        a_en = 1'b0; a_data = 16'd100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_freeze_valid", a_ovalid, 0);
            chk("a_freeze_data", $signed(a_odata), 35);
        end
        a_en = 1'b1; a_valid = 1'b0;
        tick();
        tick();
        chk("a_thaw_valid", a_ovalid, 1);
        chk("a_thaw_data", $signed(a_odata), 56);
        chk("a_thaw_chan", a_ochan, 0);

        // asynchronous reset between edges mid-stream
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        a_valid = 1'b1; a_chan = 1'b1; a_data = 16'd1;
        tick();
        tick();
        tick();
        chk("a_pre_rst_1", $signed(a_odata), 1);
        tick();
        chk("a_pre_rst_4", $signed(a_odata), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("a_async_valid", a_ovalid, 0);
        chk("a_async_data", $signed(a_odata), 0);
        chk("a_async_chan", a_ochan, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 2) begin
                chk("a_post_rst_empty", a_ovalid, 0);
            end else begin
                chk("a_post_rst_valid", a_ovalid, 1);
                chk("a_post_rst_data", $signed(a_odata), er[i-2]);
            end
        end
        a_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
